// File: rtl/rename_reg_file_if.sv
// Bus between decoder/dispatch + ROB (master side) and the rename register file (slave side).
interface rename_reg_file_if #(
    parameter int unsigned ROB_W = 4
);
    localparam int unsigned REG_W = 5;
    localparam int unsigned XLEN  = 32;

    // Pipeline control
    logic               rdy_in;
    logic               clear;

    // ROB commit port
    logic [REG_W-1:0]   commit_reg_id;
    logic [XLEN-1:0]    commit_val;
    logic [ROB_W-1:0]   commit_rob_id;

    // Dispatch rename port
    logic [REG_W-1:0]   rename_reg_id;
    logic [ROB_W-1:0]   rename_rob_id;

    // Decoder source operands
    logic [REG_W-1:0]   rs1_reg;
    logic [REG_W-1:0]   rs2_reg;

    // ROB readiness query
    logic [ROB_W-1:0]   rob_rs1_id;
    logic               rob_rs1_ready;
    logic [XLEN-1:0]    rob_rs1_val;
    logic [ROB_W-1:0]   rob_rs2_id;
    logic               rob_rs2_ready;
    logic [XLEN-1:0]    rob_rs2_val;

    // Resolved operands
    logic               rs1_dep;
    logic [ROB_W-1:0]   rs1_rob_id;
    logic [XLEN-1:0]    rs1_val;
    logic               rs2_dep;
    logic [ROB_W-1:0]   rs2_rob_id;
    logic [XLEN-1:0]    rs2_val;

    modport master (
        output rdy_in, clear,
        output commit_reg_id, commit_val, commit_rob_id,
        output rename_reg_id, rename_rob_id,
        output rs1_reg, rs2_reg,
        output rob_rs1_ready, rob_rs1_val, rob_rs2_ready, rob_rs2_val,
        input  rob_rs1_id, rob_rs2_id,
        input  rs1_dep, rs1_rob_id, rs1_val,
        input  rs2_dep, rs2_rob_id, rs2_val
    );

    modport slave (
        input  rdy_in, clear,
        input  commit_reg_id, commit_val, commit_rob_id,
        input  rename_reg_id, rename_rob_id,
        input  rs1_reg, rs2_reg,
        input  rob_rs1_ready, rob_rs1_val, rob_rs2_ready, rob_rs2_val,
        output rob_rs1_id, rob_rs2_id,
        output rs1_dep, rs1_rob_id, rs1_val,
        output rs2_dep, rs2_rob_id, rs2_val
    );
endinterface

// File: rtl/rename_reg_file.sv
// Architectural register file with per-register rename tags.
// Holds committed values, tracks the producing ROB entry of each register and
// resolves decoder source operands into a value or a pending ROB tag.
// Queries are combinational and see the state before this cycle's update.
module rename_reg_file #(
    parameter int unsigned ROB_W = 4
) (
    input  logic              clk_in,
    input  logic              rst_in,
    rename_reg_file_if.slave  bus
);
    localparam int unsigned REG_NUM = 32;
    localparam int unsigned REG_W   = 5;
    localparam int unsigned XLEN    = 32;

    logic [XLEN-1:0]    val_q [REG_NUM];
    logic [XLEN-1:0]    val_d [REG_NUM];
    logic [ROB_W-1:0]   tag_q [REG_NUM];
    logic [ROB_W-1:0]   tag_d [REG_NUM];
    logic [REG_NUM-1:0] busy_q;
    logic [REG_NUM-1:0] busy_d;

    logic [REG_NUM-1:0] commit_sel_c;
    logic [REG_NUM-1:0] rename_sel_c;
    logic [REG_NUM-1:0] retire_sel_c;

    logic               rs1_busy_c;
    logic [ROB_W-1:0]   rs1_tag_c;
    logic               rs2_busy_c;
    logic [ROB_W-1:0]   rs2_tag_c;

    // One-hot decode of commit/rename targets; bit 0 masked so x0 is never touched
    always_comb begin
        commit_sel_c = '0;
        rename_sel_c = '0;
        if (bus.commit_reg_id != '0) begin
            commit_sel_c = REG_NUM'(1) << bus.commit_reg_id;
        end
        if ((bus.rename_reg_id != '0) && !bus.clear) begin
            rename_sel_c = REG_NUM'(1) << bus.rename_reg_id;
        end
        commit_sel_c[0] = 1'b0;
        rename_sel_c[0] = 1'b0;
    end

    // Commit releases a register only if it is the latest producer and not re-renamed now
    always_comb begin
        retire_sel_c = '0;
        for (int unsigned i = 1; i < REG_NUM; i++) begin
            retire_sel_c[i] = commit_sel_c[i] && busy_q[i] &&
                              (tag_q[i] == bus.commit_rob_id) && !rename_sel_c[i];
        end
    end

    // Next-state: commit writes value, clear drops all busy, rename claims a register
    always_comb begin
        val_d  = val_q;
        tag_d  = tag_q;
        busy_d = busy_q;
        if (bus.rdy_in) begin
            for (int unsigned i = 1; i < REG_NUM; i++) begin
                if (commit_sel_c[i]) begin
                    val_d[i] = bus.commit_val;
                end
                if (bus.clear) begin
                    busy_d[i] = 1'b0;
                end else if (rename_sel_c[i]) begin
                    busy_d[i] = 1'b1;
                    tag_d[i]  = bus.rename_rob_id;
                end else if (retire_sel_c[i]) begin
                    busy_d[i] = 1'b0;
                end
            end
        end
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            for (int unsigned i = 0; i < REG_NUM; i++) begin
                val_q[i] <= '0;
                tag_q[i] <= '0;
            end
            busy_q <= '0;
        end else begin
            for (int unsigned i = 0; i < REG_NUM; i++) begin
                val_q[i] <= val_d[i];
                tag_q[i] <= tag_d[i];
            end
            busy_q <= busy_d;
        end
    end

    // Source 1 lookup: current producer tag and busy flag
    always_comb begin
        rs1_busy_c = busy_q[bus.rs1_reg];
        rs1_tag_c  = tag_q[bus.rs1_reg];
    end

    // Source 2 lookup: current producer tag and busy flag
    always_comb begin
        rs2_busy_c = busy_q[bus.rs2_reg];
        rs2_tag_c  = tag_q[bus.rs2_reg];
    end

    // Source 1 resolve: committed value, same-cycle commit bypass, ROB forward, or wait
    always_comb begin
        bus.rob_rs1_id = rs1_tag_c;
        bus.rs1_dep    = 1'b0;
        bus.rs1_rob_id = '0;
        bus.rs1_val    = '0;
        if (!rs1_busy_c) begin
            bus.rs1_val = val_q[bus.rs1_reg];
        end else if ((bus.commit_reg_id == bus.rs1_reg) &&
                     (bus.commit_rob_id == rs1_tag_c)) begin
            bus.rs1_val = bus.commit_val;
        end else if (bus.rob_rs1_ready) begin
            bus.rs1_val = bus.rob_rs1_val;
        end else begin
            bus.rs1_dep    = 1'b1;
            bus.rs1_rob_id = rs1_tag_c;
        end
    end

    // Source 2 resolve: committed value, same-cycle commit bypass, ROB forward, or wait
    always_comb begin
        bus.rob_rs2_id = rs2_tag_c;
        bus.rs2_dep    = 1'b0;
        bus.rs2_rob_id = '0;
        bus.rs2_val    = '0;
        if (!rs2_busy_c) begin
            bus.rs2_val = val_q[bus.rs2_reg];
        end else if ((bus.commit_reg_id == bus.rs2_reg) &&
                     (bus.commit_rob_id == rs2_tag_c)) begin
            bus.rs2_val = bus.commit_val;
        end else if (bus.rob_rs2_ready) begin
            bus.rs2_val = bus.rob_rs2_val;
        end else begin
            bus.rs2_dep    = 1'b1;
            bus.rs2_rob_id = rs2_tag_c;
        end
    end

endmodule

// File: tb/tb_rename_reg_file.sv
// Bench for rename_reg_file: directed scenarios then random traffic vs. a register-level model.
module tb_rename_reg_file;
    localparam int unsigned ROB_W = 4;

    logic clk_in = 1'b0;
    logic rst_in;
    int   checks = 0;
    int   errors = 0;

    // Reference state: what each architectural register holds and who produces it
    logic [31:0]      m_val  [32];
    logic             m_busy [32];
    logic [ROB_W-1:0] m_tag  [32];

    always #5 clk_in = ~clk_in;

    rename_reg_file_if #(.ROB_W(ROB_W)) bus ();

    rename_reg_file #(.ROB_W(ROB_W)) dut (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .bus    (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            m_val[i]  = '0;
            m_busy[i] = 1'b0;
            m_tag[i]  = '0;
        end
    endtask

    // Expected operand for register r given this cycle's commit and ROB answer
    task automatic mq(input logic [4:0] r, input logic ready, input logic [31:0] rv,
                      output logic dep, output logic [ROB_W-1:0] id, output logic [31:0] v);
        dep = 1'b0;
        id  = '0;
        v   = '0;
        if (r == 0) begin
            v = 0;
        end else if (!m_busy[r]) begin
            v = m_val[r];
        end else if (bus.commit_reg_id == r && bus.commit_rob_id == m_tag[r]) begin
            v = bus.commit_val;
        end else if (ready) begin
            v = rv;
        end else begin
            dep = 1'b1;
            id  = m_tag[r];
        end
    endtask

    task automatic check_outputs(input string pfx);
        logic             dep;
        logic [ROB_W-1:0] id;
        logic [31:0]      v;
        mq(bus.rs1_reg, bus.rob_rs1_ready, bus.rob_rs1_val, dep, id, v);
        chk({pfx, "_rs1_dep"}, 32'(bus.rs1_dep), 32'(dep));
        chk({pfx, "_rs1_val"}, bus.rs1_val, v);
        if (dep) chk({pfx, "_rs1_rob_id"}, 32'(bus.rs1_rob_id), 32'(id));
        chk({pfx, "_rob_rs1_id"}, 32'(bus.rob_rs1_id), 32'(m_tag[bus.rs1_reg]));
        mq(bus.rs2_reg, bus.rob_rs2_ready, bus.rob_rs2_val, dep, id, v);
        chk({pfx, "_rs2_dep"}, 32'(bus.rs2_dep), 32'(dep));
        chk({pfx, "_rs2_val"}, bus.rs2_val, v);
        if (dep) chk({pfx, "_rs2_rob_id"}, 32'(bus.rs2_rob_id), 32'(id));
        chk({pfx, "_rob_rs2_id"}, 32'(bus.rob_rs2_id), 32'(m_tag[bus.rs2_reg]));
    endtask

    // Apply the register-file update rules for the inputs present at this edge
    task automatic model_edge();
        logic [4:0] cr;
        logic [4:0] rr;
        logic       ren_ok;
        cr = bus.commit_reg_id;
        rr = bus.rename_reg_id;
        if (!rst_in || !bus.rdy_in) return;
        ren_ok = (rr != 0) && !bus.clear;
        if (cr != 0) begin
            m_val[cr] = bus.commit_val;
            if (m_busy[cr] && m_tag[cr] == bus.commit_rob_id && !(ren_ok && rr == cr))
                m_busy[cr] = 1'b0;
        end
        if (bus.clear) begin
            for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
        end else if (ren_ok) begin
            m_busy[rr] = 1'b1;
            m_tag[rr]  = bus.rename_rob_id;
        end
    endtask

    task automatic idle();
        bus.rdy_in        = 1'b1;
        bus.clear         = 1'b0;
        bus.commit_reg_id = '0;
        bus.commit_val    = '0;
        bus.commit_rob_id = '0;
        bus.rename_reg_id = '0;
        bus.rename_rob_id = '0;
        bus.rs1_reg       = '0;
        bus.rs2_reg       = '0;
        bus.rob_rs1_ready = 1'b0;
        bus.rob_rs1_val   = '0;
        bus.rob_rs2_ready = 1'b0;
        bus.rob_rs2_val   = '0;
    endtask

    // Inputs are set at negedge; check just before posedge, then advance the model
    task automatic cycle(input string pfx);
        #2;
        check_outputs(pfx);
        @(posedge clk_in);
        model_edge();
        @(negedge clk_in);
    endtask

    initial begin
        idle();
        rst_in = 1'b0;
        model_reset();
        #3;
        check_outputs("reset");
        @(negedge clk_in);
        rst_in = 1'b1;

        // Rename x5 -> tag 3; pending until ROB answers
        bus.rename_reg_id = 5'd5; bus.rename_rob_id = 4'd3;
        cycle("t2_ren");
        idle(); bus.rs1_reg = 5'd5;
        #1;
        chk("t2_dep", 32'(bus.rs1_dep), 32'd1);
        chk("t2_tag", 32'(bus.rs1_rob_id), 32'd3);
        cycle("t2_wait");
        bus.rs1_reg = 5'd5; bus.rob_rs1_ready = 1'b1; bus.rob_rs1_val = 32'h55;
        #1;
        chk("t2_fwd_dep", 32'(bus.rs1_dep), 32'd0);
        chk("t2_fwd_val", bus.rs1_val, 32'h55);
        cycle("t2_fwd");

        // Commit x5 tag 3 -> bypass now, committed next cycle
        idle(); bus.rs1_reg = 5'd5;
        bus.commit_reg_id = 5'd5; bus.commit_rob_id = 4'd3; bus.commit_val = 32'hAA;
        #1;
        chk("t3_byp_val", bus.rs1_val, 32'hAA);
        chk("t3_byp_dep", 32'(bus.rs1_dep), 32'd0);
        cycle("t3_commit");
        idle(); bus.rs1_reg = 5'd5;
        #1;
        chk("t3_after_val", bus.rs1_val, 32'hAA);
        cycle("t3_after");

        // Stale commit does not release a re-renamed register
        idle(); bus.rename_reg_id = 5'd5; bus.rename_rob_id = 4'd3;
        cycle("t4_ren3");
        idle(); bus.rename_reg_id = 5'd5; bus.rename_rob_id = 4'd7;
        cycle("t4_ren7");
        idle(); bus.commit_reg_id = 5'd5; bus.commit_rob_id = 4'd3; bus.commit_val = 32'h11;
        cycle("t4_stale");
        idle(); bus.rs1_reg = 5'd5;
        #1;
        chk("t4_dep", 32'(bus.rs1_dep), 32'd1);
        chk("t4_tag", 32'(bus.rs1_rob_id), 32'd7);
        cycle("t4_q");

        // Same-cycle commit tag 7 and rename tag 9 of x5
        idle(); bus.rs2_reg = 5'd5;
        bus.commit_reg_id = 5'd5; bus.commit_rob_id = 4'd7; bus.commit_val = 32'h22;
        bus.rename_reg_id = 5'd5; bus.rename_rob_id = 4'd9;
        #1;
        chk("t5_byp_val", bus.rs2_val, 32'h22);
        chk("t5_byp_dep", 32'(bus.rs2_dep), 32'd0);
        cycle("t5_both");
        idle(); bus.rs2_reg = 5'd5;
        #1;
        chk("t5_dep", 32'(bus.rs2_dep), 32'd1);
        chk("t5_tag", 32'(bus.rs2_rob_id), 32'd9);
        cycle("t5_q");

        // Clear drops all renames, including one in the clearing cycle
        idle(); bus.rename_reg_id = 5'd1; bus.rename_rob_id = 4'd1;
        cycle("t6_r1");
        idle(); bus.rename_reg_id = 5'd2; bus.rename_rob_id = 4'd2;
        cycle("t6_r2");
        idle(); bus.clear = 1'b1; bus.rename_reg_id = 5'd3; bus.rename_rob_id = 4'd4;
        cycle("t6_clr");
        idle(); bus.rs1_reg = 5'd1; bus.rs2_reg = 5'd2;
        cycle("t6_q12");
        idle(); bus.rs1_reg = 5'd3; bus.rs2_reg = 5'd5;
        #1;
        chk("t6_x3_dep", 32'(bus.rs1_dep), 32'd0);
        chk("t6_x5_val", bus.rs2_val, 32'h22);
        cycle("t6_q35");

        // x0 commit/rename are no-ops; rdy_in low freezes state
        idle(); bus.commit_reg_id = 5'd0; bus.commit_val = 32'hDEAD; bus.rename_reg_id = 5'd0;
        cycle("t6_x0");
        idle(); bus.rdy_in = 1'b0;
        bus.commit_reg_id = 5'd5; bus.commit_val = 32'h99; bus.commit_rob_id = 4'd0;
        bus.rename_reg_id = 5'd6; bus.rename_rob_id = 4'd5;
        cycle("t6_stall");
        idle(); bus.rs1_reg = 5'd5; bus.rs2_reg = 5'd6;
        #1;
        chk("t6_stall_val", bus.rs1_val, 32'h22);
        chk("t6_stall_dep", 32'(bus.rs2_dep), 32'd0);
        cycle("t6_q56");

        // Asynchronous reset mid-run after renaming x5
        idle(); bus.rename_reg_id = 5'd5; bus.rename_rob_id = 4'd6;
        cycle("t1_ren");
        idle(); bus.rs1_reg = 5'd5; bus.rs2_reg = 5'd5;
        #1;
        rst_in = 1'b0;
        #1;
        chk("t1_dep", 32'(bus.rs1_dep), 32'd0);
        chk("t1_val", bus.rs1_val, 32'd0);
        chk("t1_rob1", 32'(bus.rob_rs1_id), 32'd0);
        chk("t1_rob2", 32'(bus.rob_rs2_id), 32'd0);
        model_reset();
        @(posedge clk_in);
        @(negedge clk_in);
        rst_in = 1'b1;

        // Random traffic on a few registers so renames, commits and queries collide
        for (int n = 0; n < 400; n++) begin
            logic [4:0] cr;
            idle();
            bus.rdy_in = ($urandom_range(0, 9) != 0);
            bus.clear  = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 1) == 1) begin
                cr = 5'($urandom_range(0, 7));
                bus.commit_reg_id = cr;
                bus.commit_val    = $urandom;
                bus.commit_rob_id = ($urandom_range(0, 2) != 0) ? m_tag[cr] : ROB_W'($urandom);
            end
            if ($urandom_range(0, 1) == 1) begin
                bus.rename_reg_id = 5'($urandom_range(0, 7));
                bus.rename_rob_id = ROB_W'($urandom);
            end
            bus.rs1_reg       = 5'($urandom_range(0, 7));
            bus.rs2_reg       = 5'($urandom_range(0, 7));
            bus.rob_rs1_ready = 1'($urandom_range(0, 1));
            bus.rob_rs1_val   = $urandom;
            bus.rob_rs2_ready = 1'($urandom_range(0, 1));
            bus.rob_rs2_val   = $urandom;
            cycle("rnd");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
